// File: rtl/updown_load_counter_pkg.sv
// counter_pkg: shared FSM state type and counter-width helper for updown_load_counter
package counter_pkg;
  typedef enum logic [1:0] {DRIVE, RELEASE, CAPTURE} load_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/updown_load_counter_sync2.sv
// sync2: two-flop synchroniser exposing both stages so the parent can edge-detect
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s1,
  output logic o_s2
);
  logic r_s1, r_s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_s1 = r_s1;
  assign o_s2 = r_s2;
endmodule

// File: rtl/updown_load_counter.sv
// updown_load_counter: prescaled up/down modulo counter loaded over a turnaround bus
module updown_load_counter
  import counter_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MODULO        = 2**WIDTH,
  parameter int PRESCALE      = 1,
  parameter int TURN_CYCLES   = 1,
  parameter bit SATURATE      = 1'b0,
  parameter bit DEFAULT_EN    = 1'b1,
  parameter bit DEFAULT_DRIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load_req,
  input  logic             oe_req,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] bus_oe,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);
  localparam int PW = cnt_w(PRESCALE);
  localparam int RW = cnt_w(TURN_CYCLES);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  localparam logic [RW-1:0]    RMAX = RW'(TURN_CYCLES - 1);
  logic             w_en_s, w_up_s, w_oe_s, w_ld_s1, w_ld_s2;
  logic [2:0]       w_unused_s1;
  logic             w_ld_edge, w_run, w_step, w_hit, w_at_max, w_at_min;
  logic [WIDTH-1:0] w_next, w_clamp;
  load_state_t      r_state;
  logic [RW-1:0]    r_rel;
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  sync2 u_sync_en (.clk(clk), .rst(rst), .i_d(en),       .o_s1(w_unused_s1[0]), .o_s2(w_en_s));
  sync2 u_sync_up (.clk(clk), .rst(rst), .i_d(up_dn),    .o_s1(w_unused_s1[1]), .o_s2(w_up_s));
  sync2 u_sync_oe (.clk(clk), .rst(rst), .i_d(oe_req),   .o_s1(w_unused_s1[2]), .o_s2(w_oe_s));
  sync2 u_sync_ld (.clk(clk), .rst(rst), .i_d(load_req), .o_s1(w_ld_s1),        .o_s2(w_ld_s2));
  always_comb begin
    w_ld_edge = w_ld_s1 & ~w_ld_s2;
    w_run     = (r_state == DRIVE) & (DEFAULT_EN | w_en_s);
    w_step    = w_run & (r_pre == PMAX);
    w_at_max  = r_count == MAX;
    w_at_min  = r_count == '0;
    w_next    = w_up_s ? (w_at_max ? (SATURATE ? r_count : '0) : r_count + WIDTH'(1))
                       : (w_at_min ? (SATURATE ? r_count : MAX) : r_count - WIDTH'(1));
    // saturating mode pulses on arrival at a limit, wrapping mode on the wrap itself
    w_hit     = SATURATE ? (w_up_s ? r_count == MAX - WIDTH'(1) : r_count == WIDTH'(1))
                         : (w_up_s ? w_at_max : w_at_min);
    w_clamp   = (bus_in > MAX) ? MAX : bus_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DRIVE;
      r_rel   <= '0;
      r_pre   <= '0;
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= w_step & w_hit;
      if (w_run) r_pre <= (r_pre == PMAX) ? '0 : r_pre + PW'(1);
      if (w_step) r_count <= w_next;
      case (r_state)
        DRIVE: if (w_ld_edge) begin
          r_state <= RELEASE;
          r_rel   <= '0;
        end
        RELEASE: if (r_rel == RMAX) r_state <= CAPTURE;
                 else r_rel <= r_rel + RW'(1);
        CAPTURE: begin
          r_count <= w_clamp;
          r_pre   <= '0;
          r_state <= DRIVE;
        end
        default: r_state <= DRIVE;
      endcase
    end
  end
  assign count   = r_count;
  assign bus_out = r_count;
  assign bus_oe  = {WIDTH{(r_state == DRIVE) & (DEFAULT_DRIVE | w_oe_s)}};
  assign busy    = r_state != DRIVE;
  assign tc      = r_tc;
endmodule

// File: tb/tb_updown_load_counter.sv
// tb_updown_load_counter: directed vectors over four parameterisations of the counter
module tb_updown_load_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       a_en = 0, a_up = 1, a_ld = 0, a_oe = 0;
  logic [7:0] a_bin = 0, a_bout, a_boe, a_cnt;
  logic       a_tc, a_busy;
  logic       b_en = 0, b_up = 0, b_ld = 0, b_oe = 1;
  logic [7:0] b_bin = 0, b_bout, b_boe, b_cnt;
  logic       b_tc, b_busy;
  logic       c_en = 0, c_up = 1, c_ld = 0, c_oe = 0;
  logic [7:0] c_bin = 0, c_bout, c_boe, c_cnt;
  logic       c_tc, c_busy;
  logic       d_en = 0, d_up = 1, d_ld = 0, d_oe = 0;
  logic [7:0] d_bin = 0, d_bout, d_boe, d_cnt;
  logic       d_tc, d_busy;
  updown_load_counter #(.TURN_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .load_req(a_ld), .oe_req(a_oe),
    .bus_in(a_bin), .bus_out(a_bout), .bus_oe(a_boe), .count(a_cnt), .tc(a_tc), .busy(a_busy));
  updown_load_counter #(.MODULO(10), .DEFAULT_DRIVE(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .load_req(b_ld), .oe_req(b_oe),
    .bus_in(b_bin), .bus_out(b_bout), .bus_oe(b_boe), .count(b_cnt), .tc(b_tc), .busy(b_busy));
  updown_load_counter #(.MODULO(10), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(c_up), .load_req(c_ld), .oe_req(c_oe),
    .bus_in(c_bin), .bus_out(c_bout), .bus_oe(c_boe), .count(c_cnt), .tc(c_tc), .busy(c_busy));
  updown_load_counter #(.PRESCALE(4), .DEFAULT_EN(1'b0)) u_d (
    .clk(clk), .rst(rst), .en(d_en), .up_dn(d_up), .load_req(d_ld), .oe_req(d_oe),
    .bus_in(d_bin), .bus_out(d_bout), .bus_oe(d_boe), .count(d_cnt), .tc(d_tc), .busy(d_busy));
  typedef struct {
    logic       ld;
    logic [7:0] bin;
    logic [7:0] cnt;
    logic       busy;
    logic [7:0] boe;
    logic       tc;
  } vec_t;
  vec_t tbl [8];
  int n_chk = 0;
  int n_err = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask
  initial begin
    tbl[0] = '{1'b1, 8'h33, 8'h01, 1'b0, 8'hFF, 1'b0};
    tbl[1] = '{1'b0, 8'h33, 8'h02, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 8'h02, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 8'h33, 8'h02, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'h5A, 8'h5A, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{1'b1, 8'h77, 8'h5B, 1'b0, 8'hFF, 1'b0};
    tbl[6] = '{1'b1, 8'h77, 8'h5C, 1'b0, 8'hFF, 1'b0};
    tbl[7] = '{1'b0, 8'h77, 8'h5D, 1'b0, 8'hFF, 1'b0};
    do_reset();
    chk("rst_cnt", a_cnt, 8'h00);
    chk("rst_tc", a_tc, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_boe", a_boe, 8'hFF);
    chk("rst_b_boe", b_boe, 8'h00);
    rst = 1'b0;
    // synchronised direction is 0 for the first two steps after reset
    for (int k = 1; k <= 260; k++) begin
      logic [7:0] e_cnt;
      tick();
      e_cnt = (k == 1) ? 8'hFF : (k == 2) ? 8'hFE : (k == 3) ? 8'hFF : 8'((k - 4) & 255);
      chk("free_cnt", a_cnt, e_cnt);
      chk("free_tc", a_tc, (k == 1 || k == 4 || k == 260));
      chk("free_boe", a_boe, 8'hFF);
    end
    for (int i = 0; i < 8; i++) begin
      a_ld  = tbl[i].ld;
      a_bin = tbl[i].bin;
      tick();
      chk("load_cnt", a_cnt, tbl[i].cnt);
      chk("load_bout", a_bout, tbl[i].cnt);
      chk("load_busy", a_busy, tbl[i].busy);
      chk("load_boe", a_boe, tbl[i].boe);
      chk("load_tc", a_tc, tbl[i].tc);
    end
    a_ld = 1'b1;
    tick();
    chk("mid_cnt", a_cnt, 8'h5E);
    tick();
    chk("mid_busy", a_busy, 1'b1);
    chk("mid_cnt2", a_cnt, 8'h5F);
    a_bin = 8'hAA;
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", a_cnt, 8'h00);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_tc", a_tc, 1'b0);
    chk("mid_rst_boe", a_boe, 8'hFF);
    rst = 1'b0;
    a_ld = 1'b0;
    tick();
    chk("post_rst_cnt", a_cnt, 8'hFF);
    chk("post_rst_busy", a_busy, 1'b0);
    do_reset();
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("m10_cnt", b_cnt, 8'((10 - (k % 10)) % 10));
      chk("m10_tc", b_tc, (k == 1 || k == 11));
      chk("m10_boe", b_boe, (k >= 2) ? 8'hFF : 8'h00);
    end
    b_bin = 8'hC8;
    b_ld  = 1'b1;
    tick();
    chk("m10_g1", b_cnt, 8'd8);
    tick();
    chk("m10_g2", b_cnt, 8'd7);
    chk("m10_g2_busy", b_busy, 1'b1);
    chk("m10_g2_boe", b_boe, 8'h00);
    tick();
    chk("m10_g3", b_cnt, 8'd7);
    tick();
    chk("m10_clamp", b_cnt, 8'd9);
    chk("m10_clamp_tc", b_tc, 1'b0);
    chk("m10_clamp_busy", b_busy, 1'b0);
    tick();
    chk("m10_g5", b_cnt, 8'd8);
    c_bin = 8'd7;
    do_reset();
    c_ld = 1'b1;
    rst  = 1'b0;
    tick();
    tick();
    chk("sat_min_cnt", c_cnt, 8'd0);
    chk("sat_min_tc", c_tc, 1'b0);
    chk("sat_busy", c_busy, 1'b1);
    tick();
    tick();
    chk("sat_load", c_cnt, 8'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat_cnt", c_cnt, (k == 0) ? 8'd8 : 8'd9);
      chk("sat_tc", c_tc, (k == 1));
    end
    do_reset();
    rst = 1'b0;
    repeat (6) tick();
    chk("pre_frozen", d_cnt, 8'd0);
    d_en = 1'b1;
    repeat (5) tick();
    chk("pre_h5", d_cnt, 8'd0);
    tick();
    chk("pre_h6", d_cnt, 8'd1);
    repeat (3) tick();
    chk("pre_h9", d_cnt, 8'd1);
    tick();
    chk("pre_h10", d_cnt, 8'd2);
    d_up = 1'b0;
    repeat (3) tick();
    chk("pre_h13", d_cnt, 8'd2);
    tick();
    chk("pre_dir", d_cnt, 8'd1);
    chk("pre_boe", d_boe, 8'hFF);
    d_en = 1'b0;
    repeat (10) tick();
    chk("pre_stop", d_cnt, 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
